// File: rtl/lt24_touch_sequencer.sv
// LT24 touch sequencer: debounces pen-down, runs alternating X/Y ADS7843 SPI frames,
// averages 2^AVG_LOG2 pairs per report, repeats while held and flags release.
module lt24_touch_sequencer #(
  parameter int unsigned CLK_DIV         = 25,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned AVG_LOG2        = 2,
  parameter int unsigned REPEAT_CYCLES   = 500000,
  parameter logic [7:0]  CMD_X           = 8'hD0,
  parameter logic [7:0]  CMD_Y           = 8'h90
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pen_irq_n,
  input  logic        spi_miso,
  output logic        spi_mosi,
  output logic        spi_sclk,
  output logic        spi_ss_n,
  output logic        touch_valid,
  output logic [11:0] touch_x,
  output logic [11:0] touch_y,
  output logic        pen_down,
  output logic        touch_release,
  output logic        active
);

  localparam int unsigned W1   = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int unsigned WMAX = (W1 > 2 * CLK_DIV) ? W1 : 2 * CLK_DIV;
  localparam int unsigned CW   = $clog2(WMAX + 1);
  localparam int unsigned DW   = $clog2(CLK_DIV + 1);
  localparam int unsigned AW   = 12 + AVG_LOG2;
  localparam int unsigned PW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'((1 << AVG_LOG2) - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DEBOUNCE = 4'd1;
  localparam logic [3:0] S_FRAME_X  = 4'd2;
  localparam logic [3:0] S_FRAME_Y  = 4'd3;
  localparam logic [3:0] S_SETTLE   = 4'd4;
  localparam logic [3:0] S_CHECK    = 4'd5;
  localparam logic [3:0] S_REPORT   = 4'd6;
  localparam logic [3:0] S_REPEAT   = 4'd7;
  localparam logic [3:0] S_RELEASE  = 4'd8;

  localparam logic [1:0] F_LEAD = 2'd0;
  localparam logic [1:0] F_LO   = 2'd1;
  localparam logic [1:0] F_HI   = 2'd2;
  localparam logic [1:0] F_GAP  = 2'd3;

  logic          sync1_q, sync2_q;
  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fph_q, fph_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic [11:0]   shr_q, shr_d;
  logic [AW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [PW-1:0] pair_q, pair_d;
  logic          abort_q, abort_d;
  logic          ss_n_q, ss_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic [11:0]   tx_q, tx_d, ty_q, ty_d;
  logic          valid_q, valid_d, rel_q, rel_d, pen_down_q, pen_down_d;
  logic          start_frame;
  logic          pen_up;
  logic [7:0]    cmd;
  logic [4:0]    nb;

  assign pen_up = sync2_q;
  assign cmd    = (state_q == S_FRAME_Y) ? CMD_Y : CMD_X;
  assign nb     = bit_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fph_d       = fph_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shr_d       = shr_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    pair_d      = pair_q;
    abort_d     = abort_q;
    ss_n_d      = ss_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    pen_down_d  = pen_down_q;
    valid_d     = 1'b0;
    rel_d       = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && !pen_up) begin
          state_d = S_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!enable || pen_up) begin
          state_d = S_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = S_FRAME_X;
          pen_down_d  = 1'b1;
          pair_d      = '0;
          acc_x_d     = '0;
          acc_y_d     = '0;
          start_frame = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FRAME_X, S_FRAME_Y: begin
        // A frame always runs to completion; a dropped enable is remembered until the guard ends.
        if (!enable) abort_d = 1'b1;
        if (fph_q == F_HI && div_q == '0 && bit_q >= 5'd9 && bit_q <= 5'd20)
          shr_d = {shr_q[10:0], spi_miso};
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          case (fph_q)
            F_LEAD: begin
              fph_d  = F_LO;
              mosi_d = cmd[7];
            end
            F_LO: begin
              fph_d  = F_HI;
              sclk_d = 1'b1;
            end
            F_HI: begin
              sclk_d = 1'b0;
              if (bit_q == 5'd23) begin
                fph_d  = F_GAP;
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
                if (state_q == S_FRAME_X) acc_x_d = acc_x_q + AW'(shr_q);
                else                      acc_y_d = acc_y_q + AW'(shr_q);
              end else begin
                bit_d  = nb;
                fph_d  = F_LO;
                mosi_d = (nb < 5'd8) ? cmd[3'd7 - nb[2:0]] : 1'b0;
              end
            end
            default: begin
              if (!enable || abort_q) begin
                state_d = S_RELEASE;
              end else if (state_q == S_FRAME_X) begin
                state_d     = S_FRAME_Y;
                start_frame = 1'b1;
              end else begin
                state_d = S_SETTLE;
                cnt_d   = '0;
              end
            end
          endcase
        end
      end
      S_SETTLE: begin
        if (!enable)                state_d = S_RELEASE;
        else if (cnt_q == SET_LAST) state_d = S_CHECK;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      S_CHECK: begin
        if (pen_up || !enable) begin
          state_d = S_RELEASE;
        end else if (pair_q != PAIR_LAST) begin
          pair_d      = pair_q + 1'b1;
          state_d     = S_FRAME_X;
          start_frame = 1'b1;
        end else begin
          state_d = S_REPORT;
          valid_d = 1'b1;
          tx_d    = acc_x_q[AW-1:AVG_LOG2];
          ty_d    = acc_y_q[AW-1:AVG_LOG2];
          acc_x_d = '0;
          acc_y_d = '0;
          pair_d  = '0;
          cnt_d   = '0;
        end
      end
      S_REPORT: state_d = S_REPEAT;
      S_REPEAT: begin
        if (pen_up || !enable) begin
          state_d = S_RELEASE;
        end else if (cnt_q == REP_LAST) begin
          state_d     = S_FRAME_X;
          start_frame = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        abort_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_frame) begin
      ss_n_d  = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
      fph_d   = F_LEAD;
      div_d   = '0;
      bit_d   = '0;
      shr_d   = '0;
      abort_d = 1'b0;
    end
    // Registered strobes line up with the state they announce.
    if (state_d == S_RELEASE && state_q != S_RELEASE) begin
      rel_d      = 1'b1;
      pen_down_d = 1'b0;
      acc_x_d    = '0;
      acc_y_d    = '0;
      pair_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fph_q      <= F_LEAD;
      div_q      <= '0;
      bit_q      <= '0;
      shr_q      <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      pair_q     <= '0;
      abort_q    <= 1'b0;
      ss_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_q       <= '0;
      ty_q       <= '0;
      valid_q    <= 1'b0;
      rel_q      <= 1'b0;
      pen_down_q <= 1'b0;
    end else begin
      sync1_q    <= pen_irq_n;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fph_q      <= fph_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shr_q      <= shr_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      pair_q     <= pair_d;
      abort_q    <= abort_d;
      ss_n_q     <= ss_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      valid_q    <= valid_d;
      rel_q      <= rel_d;
      pen_down_q <= pen_down_d;
    end
  end

  assign spi_ss_n      = ss_n_q;
  assign spi_sclk      = sclk_q;
  assign spi_mosi      = mosi_q;
  assign touch_valid   = valid_q;
  assign touch_release = rel_q;
  assign touch_x       = tx_q;
  assign touch_y       = ty_q;
  assign pen_down      = pen_down_q;
  assign active        = (state_q != S_IDLE);

endmodule

// File: tb/tb_lt24_touch_sequencer.sv
// Bench for lt24_touch_sequencer: ADC model on the SPI pins, strobe monitor, scenario checks.
module tb_lt24_touch_sequencer;

  localparam int CD   = 2;
  localparam int DEB  = 8;
  localparam int AVG  = 1;
  localparam int REP  = 20;
  localparam int NP   = 1 << AVG;
  localparam int FLOW = 49 * CD;
  // Report-to-report: report cycle, repeat wait, then per pair two frames (low time plus
  // CD guard), a 2*CD settle and one check cycle.
  localparam int INTV = 1 + REP + NP * (2 * (FLOW + CD) + 2 * CD + 1);

  logic        clk = 1'b0;
  logic        reset_n, enable, pen_irq_n;
  logic        spi_miso = 1'b0;
  logic        spi_mosi, spi_sclk, spi_ss_n;
  logic        touch_valid, pen_down, touch_release, active;
  logic [11:0] touch_x, touch_y;

  lt24_touch_sequencer #(
    .CLK_DIV(CD), .DEBOUNCE_CYCLES(DEB), .AVG_LOG2(AVG), .REPEAT_CYCLES(REP),
    .CMD_X(8'hD0), .CMD_Y(8'h90)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pen_irq_n(pen_irq_n),
    .spi_miso(spi_miso), .spi_mosi(spi_mosi), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
    .touch_valid(touch_valid), .touch_x(touch_x), .touch_y(touch_y),
    .pen_down(pen_down), .touch_release(touch_release), .active(active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model and monitors, all sampled on the falling clk edge.
  logic [11:0] xq[$], yq[$];
  logic [7:0]  f_cmd[$];
  int          f_len[$], f_rise[$];
  int          v_cyc[$];
  logic [11:0] v_x[$], v_y[$];
  int          n_rel = 0, frame_starts = 0, rises = 0, low = 0, cyc = 0;
  logic [7:0]  cmd_sh = 8'h00;
  logic [11:0] cur = 12'h000;
  logic        prev_ss = 1'b1, prev_sclk = 1'b0, pd_seen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_ss && !spi_ss_n) begin
      rises = 0; cmd_sh = 8'h00; low = 0; spi_miso = 1'b0; frame_starts++;
    end
    if (!spi_ss_n) low++;
    if (!prev_sclk && spi_sclk) begin
      if (rises < 8) cmd_sh = {cmd_sh[6:0], spi_mosi};
      rises++;
    end else if (prev_sclk && !spi_sclk && !spi_ss_n) begin
      if (rises == 9) begin
        cur = 12'h000;
        if (cmd_sh == 8'hD0 && xq.size() > 0) cur = xq.pop_front();
        if (cmd_sh == 8'h90 && yq.size() > 0) cur = yq.pop_front();
      end
      spi_miso = (rises >= 9 && rises <= 20) ? cur[20 - rises] : 1'b0;
    end
    if (!prev_ss && spi_ss_n) begin
      f_cmd.push_back(cmd_sh); f_len.push_back(low); f_rise.push_back(rises);
    end
    if (touch_valid) begin
      v_cyc.push_back(cyc); v_x.push_back(touch_x); v_y.push_back(touch_y);
    end
    if (touch_release) n_rel++;
    if (touch_valid && touch_release) chk("vld_rel_same_cycle", 32'd1, 32'd0);
    if (pen_down) pd_seen = 1'b1;
    prev_ss   = spi_ss_n;
    prev_sclk = spi_sclk;
  end

  task automatic clear_mon();
    xq.delete(); yq.delete(); f_cmd.delete(); f_len.delete(); f_rise.delete();
    v_cyc.delete(); v_x.delete(); v_y.delete();
    n_rel = 0; frame_starts = 0; pd_seen = 1'b0;
  endtask

  task automatic press();
    int i;
    pen_irq_n = 1'b0;
    for (i = 0; i < 40 && !pen_down; i++) @(negedge clk);
    chk("press_pen_down", {31'd0, pen_down}, 32'd1);
  endtask

  task automatic wait_valids(input int n, input int budget);
    for (int i = 0; i < budget && v_x.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frame_starts < n; i++) @(negedge clk);
  endtask

  task automatic release_and_idle();
    pen_irq_n = 1'b1;
    repeat (40) @(negedge clk);
    clear_mon();
  endtask

  logic [11:0] rx[6], ry[6];
  int          k, exp_x, exp_y;

  initial begin
    reset_n = 1'b0; enable = 1'b0; pen_irq_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {25'd0, spi_ss_n, spi_sclk, spi_mosi, touch_valid, touch_release, pen_down, active},
        32'h40);
    chk("rst_x", {20'd0, touch_x}, 32'd0);
    chk("rst_y", {20'd0, touch_y}, 32'd0);
    reset_n = 1'b1; enable = 1'b1;
    repeat (4) @(negedge clk);

    // Debounce reject: 5 low cycles is short of DEB.
    pen_irq_n = 1'b0;
    repeat (5) @(negedge clk);
    pen_irq_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("deb_frames", frame_starts, 0);
    chk("deb_pen_down", {31'd0, pd_seen}, 32'd0);
    chk("deb_active", {31'd0, active}, 32'd0);
    clear_mon();

    // Single press, then release 5 cycles into the repeat wait.
    xq.push_back(12'h123); xq.push_back(12'h125);
    yq.push_back(12'h800); yq.push_back(12'h802);
    press();
    for (k = 0; k < 2000 && !touch_valid; k++) @(negedge clk);
    chk("single_vld_seen", {31'd0, touch_valid}, 32'd1);
    chk("single_x", {20'd0, touch_x}, 32'h124);
    chk("single_y", {20'd0, touch_y}, 32'h801);
    repeat (5) @(negedge clk);
    pen_irq_n = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (touch_release) break;
    end
    chk("rel_latency", k, 3);
    chk("rel_pen_down", {31'd0, pen_down}, 32'd0);
    chk("rel_x_hold", {20'd0, touch_x}, 32'h124);
    chk("rel_y_hold", {20'd0, touch_y}, 32'h801);
    repeat (10) @(negedge clk);
    chk("single_nvld", v_x.size(), 1);
    chk("single_nframes", f_cmd.size(), 2 * NP);
    for (int i = 0; i < f_cmd.size() && i < 2 * NP; i++) begin
      chk($sformatf("single_cmd%0d", i), {24'd0, f_cmd[i]}, (i % 2 == 0) ? 32'hD0 : 32'h90);
      chk($sformatf("single_len%0d", i), f_len[i], FLOW);
      chk($sformatf("single_rise%0d", i), f_rise[i], 24);
    end
    release_and_idle();

    // Hold for three reports with random samples.
    for (int i = 0; i < 6; i++) begin
      rx[i] = 12'($urandom_range(0, 4095)); ry[i] = 12'($urandom_range(0, 4095));
      xq.push_back(rx[i]); yq.push_back(ry[i]);
    end
    press();
    wait_valids(3, 3000);
    pen_irq_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("hold_nvld", v_x.size(), 3);
    chk("hold_nrel", n_rel, 1);
    for (int i = 0; i < 3 && i < v_x.size(); i++) begin
      exp_x = (int'(rx[2*i]) + int'(rx[2*i+1])) / NP;
      exp_y = (int'(ry[2*i]) + int'(ry[2*i+1])) / NP;
      chk($sformatf("hold_x%0d", i), {20'd0, v_x[i]}, exp_x);
      chk($sformatf("hold_y%0d", i), {20'd0, v_y[i]}, exp_y);
      if (i > 0) chk($sformatf("hold_intv%0d", i), v_cyc[i] - v_cyc[i-1], INTV);
    end
    release_and_idle();

    // Pen lifted during the first Y frame: frame finishes, data discarded.
    xq.push_back(12'($urandom_range(0, 4095))); yq.push_back(12'($urandom_range(0, 4095)));
    press();
    wait_frames(2, 400);
    repeat (20) @(negedge clk);
    pen_irq_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("chk_rel_nvld", v_x.size(), 0);
    chk("chk_rel_nrel", n_rel, 1);
    chk("chk_rel_nframes", f_len.size(), 2);
    if (f_len.size() >= 2) chk("chk_rel_ylen", f_len[1], FLOW);
    chk("chk_rel_pen_down", {31'd0, pen_down}, 32'd0);
    release_and_idle();

    // Full-scale X.
    exp_y = $urandom_range(0, 4095);
    xq.push_back(12'hFFF); xq.push_back(12'hFFF);
    yq.push_back(12'(exp_y)); yq.push_back(12'(exp_y));
    press();
    wait_valids(1, 2000);
    chk("fs_nvld", v_x.size(), 1);
    if (v_x.size() > 0) begin
      chk("fs_x", {20'd0, v_x[0]}, 32'hFFF);
      chk("fs_y", {20'd0, v_y[0]}, exp_y);
    end
    release_and_idle();

    // Enable dropped in bit period 5 of the first frame.
    press();
    for (k = 0; k < 400 && !(frame_starts == 1 && rises == 5 && !spi_sclk); k++) @(negedge clk);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    chk("en_nframes", f_len.size(), 1);
    if (f_len.size() > 0) begin
      chk("en_len", f_len[0], FLOW);
      chk("en_rise", f_rise[0], 24);
    end
    chk("en_nrel", n_rel, 1);
    chk("en_nvld", v_x.size(), 0);
    chk("en_active", {31'd0, active}, 32'd0);
    pen_irq_n = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    clear_mon();

    // Reset pulsed mid-frame.
    press();
    wait_frames(1, 200);
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_ctrl", {25'd0, spi_ss_n, spi_sclk, spi_mosi, touch_valid, touch_release, pen_down, active},
        32'h40);
    chk("rstmid_x", {20'd0, touch_x}, 32'd0);
    pen_irq_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rstmid_nvld", v_x.size(), 0);
    chk("rstmid_nrel", n_rel, 0);
    chk("rstmid_active", {31'd0, active}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
